// File: rtl/fft_bfly_sched.sv
// Butterfly scheduler for one radix-2 FFT stage: buffers a frame, issues operand
// pairs to an external complex multiply/add datapath, collects results and streams them out.
module fft_bfly_sched #(
  parameter int unsigned NPT = 32,
  parameter int unsigned AW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [63:0]   in_data,
  output logic          in_ready,
  output logic          bf_valid,
  output logic [63:0]   bf_a,
  output logic [63:0]   bf_b,
  output logic [AW-1:0] bf_widx,
  input  logic          res_valid,
  input  logic [63:0]   res_data,
  output logic          out_valid,
  output logic [63:0]   out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          err
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(NPT);
  localparam logic [CW-1:0] LAST = CW'(NPT - 1);

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, UNLOAD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] ld_cnt, is_cnt, rs_cnt, rd_cnt, ul_cnt;
  logic [63:0]   dbuf [NPT];
  logic [63:0]   rbuf [NPT];
  logic          ld_take, res_take, out_xfer, frame_done;

  assign ld_take    = (state == LOAD) && in_valid;
  assign res_take   = res_valid && (state != LOAD) && (rs_cnt != FULL);
  assign out_xfer   = out_valid && out_ready;
  assign frame_done = (state == UNLOAD) && (state_nx == LOAD);
  assign busy       = (state != LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  // Next state plus the combinational issue port.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    bf_valid = 1'b0;
    bf_a     = '0;
    bf_b     = '0;
    bf_widx  = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (ld_take && ld_cnt == LAST) state_nx = ISSUE;
      end
      ISSUE: begin
        bf_valid = 1'b1;
        bf_widx  = is_cnt[AW-1:0];
        bf_a     = dbuf[{1'b0, is_cnt[AW-2:0]}];
        bf_b     = dbuf[{1'b1, is_cnt[AW-2:0]}];
        if (is_cnt == LAST) begin
          // A result landing alongside the last issue still counts as complete.
          if (rs_cnt == FULL || (res_take && rs_cnt == LAST)) state_nx = UNLOAD;
          else                                                 state_nx = WAIT;
        end
      end
      WAIT: begin
        if (rs_cnt == FULL) state_nx = UNLOAD;
      end
      UNLOAD: begin
        if (out_xfer && ul_cnt == LAST) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Buffers carry no reset; their contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (ld_take)  dbuf[ld_cnt[AW-1:0]] <= in_data;
    if (res_take) rbuf[rs_cnt[AW-1:0]] <= res_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt    <= '0;
      is_cnt    <= '0;
      rs_cnt    <= '0;
      rd_cnt    <= '0;
      ul_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      if (res_valid && !res_take) err <= 1'b1;
      if (ld_take)                ld_cnt <= ld_cnt + CW'(1);
      if (state == ISSUE)         is_cnt <= is_cnt + CW'(1);
      if (res_take)               rs_cnt <= rs_cnt + CW'(1);
      if (state == UNLOAD) begin
        // Output register refills only when empty or draining, so it holds under stall.
        if (!out_valid || out_ready) begin
          if (rd_cnt != FULL) begin
            out_data  <= rbuf[rd_cnt[AW-1:0]];
            out_valid <= 1'b1;
            rd_cnt    <= rd_cnt + CW'(1);
          end else begin
            out_valid <= 1'b0;
          end
        end
        if (out_xfer) ul_cnt <= ul_cnt + CW'(1);
      end
      if (frame_done) begin
        ld_cnt    <= '0;
        is_cnt    <= '0;
        rs_cnt    <= '0;
        rd_cnt    <= '0;
        ul_cnt    <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Scoreboard bench for fft_bfly_sched: expected issues and output beats are queued at
// stimulus time and checked by independent monitors; a bench datapath returns a + w*b.
module tb_fft_bfly_sched;

  localparam int NPT = 32;
  localparam int AW  = 5;

  typedef struct packed {
    logic [AW-1:0] w;
    logic [63:0]   a;
    logic [63:0]   b;
  } op_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [63:0]   in_data = '0;
  logic          in_ready;
  logic          bf_valid;
  logic [63:0]   bf_a, bf_b;
  logic [AW-1:0] bf_widx;
  logic          res_valid;
  logic [63:0]   res_data;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          out_ready = 1'b1;
  logic          busy, err;

  logic          lat0 = 1'b0;
  logic          inj = 1'b0;
  logic [2:0]    p_v;
  logic [63:0]   p_d [3];

  op_t           opq [$];
  logic [63:0]   outq [$];
  int            errs = 0;
  int            checks = 0;

  fft_bfly_sched #(.NPT(NPT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bf_valid(bf_valid), .bf_a(bf_a), .bf_b(bf_b), .bf_widx(bf_widx),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dp(input logic [63:0] a, input logic [63:0] b,
                                     input logic [AW-1:0] w);
    return a + 64'(w) * b;
  endfunction

  // Bench datapath: latency 3 pipeline, or combinational when lat0 is set.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_v <= '0;
    end else begin
      p_v    <= {p_v[1:0], bf_valid && !lat0};
      p_d[0] <= dp(bf_a, bf_b, bf_widx);
      p_d[1] <= p_d[0];
      p_d[2] <= p_d[1];
    end
  end

  assign res_valid = inj | (lat0 ? bf_valid : p_v[2]);
  assign res_data  = inj ? 64'hDEAD_BEEF_0BAD_F00D :
                     (lat0 ? dp(bf_a, bf_b, bf_widx) : p_d[2]);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue monitor.
  logic prev_bf = 1'b0;
  always @(negedge clk) begin
    op_t e;
    if (bf_valid) begin
      if (opq.size() == 0) begin
        checks++; errs++;
        $display("FAIL bf_unexpected: got widx %0d expected no issue", bf_widx);
      end else begin
        e = opq.pop_front();
        chk("bf_widx", 64'(bf_widx), 64'(e.w));
        chk("bf_a", bf_a, e.a);
        chk("bf_b", bf_b, e.b);
      end
      if (bf_widx != '0) chk("bf_back_to_back", 64'(prev_bf), 64'd1);
    end
    prev_bf = bf_valid;
  end

  // Output monitor: stream order, stall stability, and in_ready gating while busy.
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev && out_valid) chk("out_stable", out_data, stall_data);
      if (out_valid && out_ready) begin
        if (outq.size() == 0) begin
          checks++; errs++;
          $display("FAIL out_unexpected: got %h expected no beat", out_data);
        end else begin
          chk("out_data", out_data, outq.pop_front());
        end
      end
      if (busy) chk("in_ready_busy", 64'(in_ready), 64'd0);
    end
    stall_prev = out_valid && !out_ready && !rst;
    stall_data = out_data;
  end

  task automatic push_frame();
    for (int j = 0; j < NPT; j++) begin
      int m;
      op_t e;
      m = j % (NPT / 2);
      e.w = AW'(j);
      e.a = 64'(m) << 32;
      e.b = 64'(m + NPT / 2) << 32;
      opq.push_back(e);
      outq.push_back(64'(m + j * (m + NPT / 2)) << 32);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_bf_valid"}, 64'(bf_valid), 64'd0);
    chk({tag, "_bf_a"}, bf_a, 64'd0);
    chk({tag, "_bf_b"}, bf_b, 64'd0);
    chk({tag, "_bf_widx"}, 64'(bf_widx), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic run_frame(input bit l0, input bit tog, input bit hold, input bit extra,
                           output int busy_cycles);
    int  n;
    bit  injected;
    lat0 = l0;
    push_frame();
    for (int k = 0; k < NPT; k++) begin
      in_valid = 1'b1;
      in_data  = 64'(k) << 32;
      @(posedge clk); #1;
    end
    in_valid = hold;
    in_data  = 64'hBAAD_BAAD_BAAD_BAAD;
    n = 0;
    injected = 1'b0;
    while (busy && n < 2000) begin
      n++;
      out_ready = tog ? ~out_ready : 1'b1;
      if (extra && out_valid && !injected) begin
        inj = 1'b1;
        injected = 1'b1;
      end
      @(posedge clk); #1;
      inj = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (n >= 2000) chk("frame_timeout", 64'(n), 64'd0);
    if (extra) chk("extra_injected", 64'(injected), 64'd1);
    busy_cycles = n;
    chk("in_ready_after", 64'(in_ready), 64'd1);
    chk("issues_left", 64'(opq.size()), 64'd0);
    chk("beats_left", 64'(outq.size()), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("rst");

    run_frame(1'b0, 1'b0, 1'b0, 1'b0, n);
    chk("err_lat3", 64'(err), 64'd0);

    run_frame(1'b1, 1'b0, 1'b0, 1'b0, n);
    chk("busy_cycles_lat0", 64'(n), 64'd65);
    chk("err_lat0", 64'(err), 64'd0);

    run_frame(1'b0, 1'b1, 1'b1, 1'b0, n);
    chk("err_hold_in", 64'(err), 64'd0);

    run_frame(1'b0, 1'b0, 1'b0, 1'b1, n);
    chk("err_set", 64'(err), 64'd1);
    repeat (5) @(posedge clk);
    #1 chk("err_sticky", 64'(err), 64'd1);

    lat0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 64'hFFFF_0000_0000_0000 | 64'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1 chk_reset("midrst");
    @(posedge clk); #1 rst = 1'b0;
    chk_reset("postrst");
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, n);
    chk("err_after_rst_frame", 64'(err), 64'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fft_bfly_sched.md
FFT_BFLY_SCHED -- requirements
Module: fft_bfly_sched

Interface
REQ-001 SHALL provide parameter NPT, default 32, meaning points per stage (power of two, >=4).
REQ-002 SHALL provide parameter AW, default 5, meaning log2(NPT), the index width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning a sample is offered.
REQ-006 SHALL have port in_data, input, 64, meaning a complex sample: [63:32] real float32, [31:0] imag float32.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-008 SHALL have port bf_valid, output, 1, meaning an operation is issued to the external compmult/compadder pair.
REQ-009 SHALL have ports bf_a and bf_b, output, 64 each, meaning the adder operand and the multiplier operand.
REQ-010 SHALL have port bf_widx, output, AW, meaning the twiddle index (0..NPT-1).
REQ-011 SHALL have ports res_valid (input, 1) and res_data (input, 64), meaning a datapath result is returned.
REQ-012 SHALL have ports out_valid (output, 1), out_data (output, 64) and out_ready (input, 1), meaning a result stream.
REQ-013 SHALL have port busy, output, 1, meaning state is not LOAD.
REQ-014 SHALL have port err, output, 1, meaning a sticky protocol error.

Function
REQ-015 SHALL implement states LOAD, ISSUE, WAIT and UNLOAD; reset enters LOAD.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready writes sample buffer[ld_cnt], ld_cnt++; the NPTth accept moves to ISSUE next cycle.
REQ-017 ISSUE: one op per cycle for j=0..NPT-1, with bf_valid=1, bf_a=buf[j mod NPT/2], bf_b=buf[(j mod NPT/2)+NPT/2] and bf_widx=j; after j=NPT-1 go to WAIT.
REQ-018 Issued operands SHALL be combinational from buffer and issue counter; there is no backpressure from the datapath.
REQ-019 Results SHALL be accepted in any state except LOAD; the res_valid cycle writes result buffer[rs_cnt], rs_cnt++. Datapath latency is unknown but in-order and >=0 cycles, and a result may arrive in the same cycle as its issue.
REQ-020 WAIT->UNLOAD SHALL occur the cycle after rs_cnt reaches NPT; ISSUE->UNLOAD directly if all results have already arrived.
REQ-021 UNLOAD: out_valid=1, out_data=result buffer[ul_cnt]; ul_cnt++ on out_valid&out_ready; after the NPTth transfer go to LOAD and clear all counters.
REQ-022 out_data SHALL hold stable while out_valid&!out_ready.
REQ-023 res_valid in LOAD, or with rs_cnt==NPT, SHALL be ignored (no write) and set err; err clears only on rst.
REQ-024 in_valid outside LOAD SHALL be ignored with in_ready=0; it is not an error.
REQ-025 Counters SHALL be AW+1 bits wide; there is no wrap-around within a frame.

Reset
REQ-026 On rst: state=LOAD, all counters=0, in_ready=1, bf_valid=0, bf_a=bf_b=0, bf_widx=0, out_valid=0, out_data=0, busy=0, err=0; buffer contents are undefined.
REQ-027 rst asserted mid-frame SHALL abort the frame; the first post-reset accepted sample is index 0.

Verification
REQ-028 Load in_data=k<<32 for k=0..31 with a latency-3 bench model of a+w*b -> bf_widx 0..31 on 32 consecutive cycles, bf_a real=j mod 16, bf_b real=(j mod 16)+16, then 32 out beats matching the model, then in_ready=1.
REQ-029 Latency-0 model (res_valid same cycle as bf_valid) -> ISSUE goes straight to UNLOAD; busy=1 for exactly 32+1+32 cycles with out_ready=1.
REQ-030 out_ready toggled 1/0 in UNLOAD -> no beat dropped or duplicated, and out_data is stable while stalled.
REQ-031 Inject an extra res_valid after the 32nd result -> err=1 and stays 1; output data is unchanged.
REQ-032 Assert rst after 10 loaded samples -> all outputs at reset values; a full new frame then completes correctly.
REQ-033 in_valid held 1 during ISSUE/UNLOAD -> in_ready=0; no sample is overwritten and err=0.
